// File: rtl/debounce_pkg.sv
// Shared types and helpers for the multi-channel push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // stable low
        RISE = 2'd1,  // qualifying high
        HOLD = 2'd2,  // stable high
        FALL = 2'd3   // qualifying low
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: input synchroniser, four-state qualification FSM,
// registered level and press/release pulses.
// Optional long-press detector enabled by defining LONG_PRESS_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DELAY_CYCLES      = 2000000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_press_o
);

    if (DELAY_CYCLES < 2) begin : g_bad_delay
        $fatal(1, "debounce_channel: DELAY_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $fatal(1, "debounce_channel: SYNC_STAGES must be >= 2");
    end
    if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
        $fatal(1, "debounce_channel: LONG_PRESS_CYCLES must be >= 2");
    end

    localparam int unsigned    CW      = cnt_width(DELAY_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DELAY_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    // Input synchroniser shift register; FSM sees only the last stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    assign s = sync_q[SYNC_STAGES-1];

    // State and stable-time counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic; a qualifying state aborts on any opposite sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = RISE;
                    cnt_d   = '0;
                end
            end
            RISE: begin
                if (!s)                  state_d = IDLE;
                else if (cnt_q == CNT_MAX) state_d = HOLD;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            HOLD: begin
                if (!s) begin
                    state_d = FALL;
                    cnt_d   = '0;
                end
            end
            FALL: begin
                if (s)                   state_d = HOLD;
                else if (cnt_q == CNT_MAX) state_d = IDLE;
                else                     cnt_d   = cnt_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: level and pulses change only on qualified transitions.
    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (state_q == RISE && state_d == HOLD) begin
            level_d = 1'b1;
            press_d = 1'b1;
        end
        if (state_q == FALL && state_d == IDLE) begin
            level_d   = 1'b0;
            release_d = 1'b1;
        end
    end

    // Registered outputs, so nothing from btn_i reaches a port combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef LONG_PRESS_EN
    localparam int unsigned   LW     = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES - 1);
    localparam logic [LW-1:0] LP_PRE = LW'(LONG_PRESS_CYCLES - 2);

    logic [LW-1:0] hold_cnt_q, hold_cnt_d;
    logic          long_q, long_d;

    // Hold counter: cleared only on a fresh press, so glitches keep progress
    // and saturation blocks a second pulse until the next qualified press.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        long_d     = 1'b0;
        if (state_q == RISE && state_d == HOLD) begin
            hold_cnt_d = '0;
        end else if ((state_q == HOLD || state_q == FALL) && hold_cnt_q != LP_MAX) begin
            hold_cnt_d = hold_cnt_q + LW'(1);
            long_d     = (hold_cnt_q == LP_PRE);
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_debouncer.sv
// N-channel push-button conditioner: NUM_CH independent debounce channels.
// Optional long-press pulse output enabled by defining LONG_PRESS_EN.
module multi_channel_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_CH            = 4,
    parameter int unsigned DELAY_CYCLES      = 2000000,
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] btn_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] press_o,
    output logic [NUM_CH-1:0] release_o,
    output logic [NUM_CH-1:0] long_press_o
);

    if (NUM_CH < 1) begin : g_bad_num_ch
        $fatal(1, "multi_channel_debouncer: NUM_CH must be >= 1");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DELAY_CYCLES      (DELAY_CYCLES),
            .SYNC_STAGES       (SYNC_STAGES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .btn_i        (btn_i[i]),
            .level_o      (level_o[i]),
            .press_o      (press_o[i]),
            .release_o    (release_o[i]),
            .long_press_o (long_press_o[i])
        );
    end

endmodule

// File: tb/tb_multi_channel_debouncer.sv
// Directed bench for multi_channel_debouncer with NUM_CH=4, DELAY_CYCLES=4,
// SYNC_STAGES=2, LONG_PRESS_CYCLES=10: a clean edge reaches press/release
// after 7 rising edges. Long-press checks follow LONG_PRESS_EN.
module tb_multi_channel_debouncer;

    logic       clk;
    logic       rst_n;
    logic [3:0] btn;
    logic [3:0] level;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] lp;

    int total = 0;
    int bad   = 0;

    multi_channel_debouncer #(
        .NUM_CH            (4),
        .DELAY_CYCLES      (4),
        .SYNC_STAGES       (2),
        .LONG_PRESS_CYCLES (10)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .btn_i        (btn),
        .level_o      (level),
        .press_o      (press),
        .release_o    (rel),
        .long_press_o (lp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_lp;

        // Reset state
        rst_n = 1'b0;
        btn   = 4'b0000;
        #12;
        chk("rst_level", level, 4'b0000);
        chk("rst_press", press, 4'b0000);
        chk("rst_rel",   rel,   4'b0000);
        chk("rst_lp",    lp,    4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);

        // Clean press on ch0
        btn = 4'b0001;
        tick(6);
        chk("clean_press_early", press, 4'b0000);
        chk("clean_level_early", level, 4'b0000);
        tick(1);
        chk("clean_press",       press, 4'b0001);
        chk("clean_level",       level, 4'b0001);
        chk("clean_rel",         rel,   4'b0000);
        tick(1);
        chk("clean_press_once",  press, 4'b0000);
        tick(12);
        chk("clean_level_hold",  level, 4'b0001);

        // Glitch on held ch0: 2 low cycles must be absorbed
        btn = 4'b0000;
        tick(2);
        btn = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_rel",   rel,   4'b0000);
            chk("glitch_level", level, 4'b0001);
        end

        // Qualified release of ch0
        btn = 4'b0000;
        tick(6);
        chk("release_early", rel,   4'b0000);
        chk("release_lvl_e", level, 4'b0001);
        tick(1);
        chk("release",       rel,   4'b0001);
        chk("release_level", level, 4'b0000);
        chk("release_press", press, 4'b0000);
        tick(1);
        chk("release_once",  rel,   4'b0000);
        tick(3);

        // Bounce on ch1: high 3 / low 1, five times
        for (int r = 0; r < 5; r++) begin
            btn = 4'b0010;
            for (int k = 0; k < 3; k++) begin
                tick(1);
                chk("bounce_press", press, 4'b0000);
            end
            btn = 4'b0000;
            tick(1);
            chk("bounce_press", press, 4'b0000);
        end
        btn = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk("bounce_settle", press, 4'b0000);
        end
        tick(1);
        chk("bounce_press_final", press, 4'b0010);
        chk("bounce_level",       level, 4'b0010);
        tick(1);
        chk("bounce_press_once",  press, 4'b0000);
        btn = 4'b0000;
        tick(6);
        tick(1);
        chk("bounce_release",     rel,   4'b0010);
        tick(3);

        // Simultaneous press/release on all channels
        btn = 4'b1111;
        tick(6);
        chk("sim_press_early", press, 4'b0000);
        tick(1);
        chk("sim_press",       press, 4'b1111);
        chk("sim_level",       level, 4'b1111);
        tick(1);
        chk("sim_press_once",  press, 4'b0000);
        tick(3);
        btn = 4'b0000;
        tick(6);
        chk("sim_rel_early",   rel,   4'b0000);
        tick(1);
        chk("sim_rel",         rel,   4'b1111);
        chk("sim_rel_level",   level, 4'b0000);
        chk("sim_rel_press",   press, 4'b0000);
        tick(1);
        chk("sim_rel_once",    rel,   4'b0000);
        tick(3);

        // Long press on ch3, held 30 cycles
        btn = 4'b1000;
        tick(7);
        chk("long_press_pulse", press, 4'b1000);
        for (int i = 1; i <= 23; i++) begin
            tick(1);
`ifdef LONG_PRESS_EN
            exp_lp = (i == 9) ? 4'b1000 : 4'b0000;
`else
            exp_lp = 4'b0000;
`endif
            chk("long_lp",    lp,    exp_lp);
            chk("long_press", press, 4'b0000);
        end
        btn = 4'b0000;
        tick(7);
        chk("long_release", rel, 4'b1000);
        tick(3);

        // Reset mid-qualification: ch0 qualified, ch2 mid-way
        btn = 4'b0001;
        tick(7);
        chk("mid_pre_press", press, 4'b0001);
        btn = 4'b0101;
        tick(5);
        chk("mid_pre_level", level, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", level, 4'b0000);
        chk("mid_rst_press", press, 4'b0000);
        chk("mid_rst_rel",   rel,   4'b0000);
        chk("mid_rst_lp",    lp,    4'b0000);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        chk("mid_req_early", press, 4'b0000);
        chk("mid_req_lvl_e", level, 4'b0000);
        tick(1);
        chk("mid_req_press", press, 4'b0101);
        chk("mid_req_level", level, 4'b0101);
        tick(1);
        chk("mid_req_once",  press, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_debouncer.md
Name: multi_channel_debouncer

Overview:
Parametrised N-channel push-button conditioner. It replaces the single-channel, press-only delayed-detection debouncer.
- Each channel synchronises a raw button input, qualifies both rising and falling transitions with a stable-time counter, and produces a registered debounced level plus one-cycle press and release pulses.
- Sits between board pins and user logic such as counters and FSM step inputs.

Parameters:
NUM_CH, 4, number of independent button channels (>=1)
DELAY_CYCLES, 2000000, stable-time qualification in clk_i cycles (>=2); 20 ms at 100 MHz
SYNC_STAGES, 2, depth of per-channel input synchroniser (>=2)
LONG_PRESS_CYCLES, 100000000, hold time for long-press pulse; used only with LONG_PRESS_EN (>=2)

Ports:
clk_i  input  1  sole clock, rising edge
rst_ni  input  1  reset, asynchronous assert, active-low
btn_i  input  NUM_CH  raw asynchronous button levels, 1 = pressed
level_o  output  NUM_CH  registered debounced level
press_o  output  NUM_CH  one-cycle pulse on qualified press
release_o  output  NUM_CH  one-cycle pulse on qualified release
long_press_o  output  NUM_CH  one-cycle pulse on long hold; constant 0 without LONG_PRESS_EN

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. While rst_ni=0, all of the following are 0 immediately: synchronisers, counters, level_o, press_o, release_o, long_press_o. All FSMs are in IDLE.
- Channels are fully independent. Events on several channels in the same cycle yield pulses on all of them in the same cycle.
- Synchroniser: SYNC_STAGES flops per channel, reset to 0. The FSM sees only the synchronised bit s.
- Counter width: max(1, $clog2(DELAY_CYCLES)). The counter never exceeds DELAY_CYCLES-1, so there is no wrap.
- Per-channel FSM states: IDLE (stable low), RISE (qualifying high), HOLD (stable high), FALL (qualifying low).
- IDLE: s=1 -> RISE, cnt<=0. Otherwise stay in IDLE.
- RISE:
  - s=0 -> IDLE, no output; the bounce is discarded.
  - s=1 and cnt<DELAY_CYCLES-1 -> cnt+1.
  - s=1 and cnt==DELAY_CYCLES-1 -> HOLD, level_o<=1, press_o<=1 for exactly one cycle.
- HOLD: s=0 -> FALL, cnt<=0. Otherwise stay in HOLD; level_o stays 1.
- FALL:
  - s=1 -> HOLD, no output; the glitch is discarded and level_o stays 1.
  - s=0 and cnt<DELAY_CYCLES-1 -> cnt+1.
  - s=0 and cnt==DELAY_CYCLES-1 -> IDLE, level_o<=0, release_o<=1 for one cycle.
- Latency: a clean edge on btn_i, meeting setup before edge 0, makes press_o or release_o high after edge SYNC_STAGES+DELAY_CYCLES+1. level_o changes on that same edge.
- Pulse rules:
  - press_o and release_o are never both high on one channel.
  - Each pulse lasts exactly one cycle.
  - level_o toggles only on the cycle its pulse fires.
- Reset mid-operation: all qualification progress is lost. A button still held at reset release is re-qualified from IDLE and produces press_o after the full latency.
- All outputs are registered; there are no combinational paths from btn_i.
- Illegal parameter values (DELAY_CYCLES<2, SYNC_STAGES<2, NUM_CH<1, LONG_PRESS_CYCLES<2) are caught by an elaboration-time $fatal.

Optional Feature:
Macro LONG_PRESS_EN.
- Defined:
  - Each channel adds a hold counter of width $clog2(LONG_PRESS_CYCLES), cleared on HOLD entry from RISE.
  - The counter increments each cycle in HOLD or FALL and saturates at LONG_PRESS_CYCLES-1.
  - When it first reaches LONG_PRESS_CYCLES-1, long_press_o pulses for one cycle.
  - There is at most one long-press pulse per press; the counter re-arms only after a qualified release.
  - A glitch (HOLD->FALL->HOLD) does not clear the counter.
- Undefined: no hold counter logic; long_press_o tied to 0. Port list is identical in both builds.

Decomposition:
- Package debounce_pkg: state enum typedef (IDLE, RISE, HOLD, FALL); function cnt_width(n) returning max(1, $clog2(n)).
- Sub-module debounce_channel: one synchroniser, FSM and counters per channel, with the same parameters except NUM_CH.
- Top level: generate loop instantiating NUM_CH debounce_channel blocks.

Test Plan:
Bench parameters for all scenarios: NUM_CH=4, DELAY_CYCLES=4, SYNC_STAGES=2, LONG_PRESS_CYCLES=10; full latency = 7 edges.
- Clean press: btn_i 0000->0001, held 20 cycles -> press_o=0001 for one cycle after edge 7; level_o[0]=1 from then; no other outputs toggle.
- Bounce rejection: btn_i[1] pattern high 3, low 1, repeated 5 times, then stable high -> no press_o[1] during bouncing; single press_o[1] 7 edges after the final stable rise.
- Release and glitch: ch0 held, drop btn_i[0] low for 2 cycles then high -> no release_o, level_o[0] stays 1. Then low for 10 cycles -> release_o=0001 one cycle after edge 7; level_o[0]=0.
- Simultaneous: btn_i 0000->1111 in one cycle -> press_o=1111 in a single cycle; later 1111->0000 -> release_o=1111 in a single cycle.
- Reset mid-qualification: btn_i[2] high, rst_ni=0 at edge 5 -> all outputs 0 immediately, without waiting for a clock edge. rst_ni=1 with btn_i[2] still high -> press_o[2] 7 edges after reset release.
- Long press (LONG_PRESS_EN defined): hold ch3 for 30 cycles -> press_o[3] once, then long_press_o[3] exactly once, 9 edges after HOLD entry; no repeat. With the macro undefined, long_press_o remains 0000 throughout.
